universal_shift_reg: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 14 +
 rtl/dff_en_cell.sv | 25 ++
 rtl/universal_shift_reg.sv | 92 +++++++++
 tb/tb_universal_shift_reg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared mode encoding and counter sizing for universal_shift_reg
package shift_reg_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Bits needed to count 0..w inclusive, so the counter can hold the saturated value w
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/dff_en_cell.sv
// rtl/dff_en_cell.sv - single-bit enabled D flip-flop with synchronous active-low reset
module dff_en_cell #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   logic q_q;

   // Reset wins over enable; otherwise capture d only when enabled
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         q_q <= RESET_BIT;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit load/shift/rotate register with shift counter
module universal_shift_reg
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               ROTATE      = 1'b0
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        enable,
   input  logic [1:0]                  mode,
   input  logic [WIDTH-1:0]            d,
   input  logic                        sin_msb,
   input  logic                        sin_lsb,
   output logic [WIDTH-1:0]            q,
   output logic                        sout_lsb,
   output logic                        sout_msb,
   output logic [cnt_width(WIDTH)-1:0] shift_cnt,
   output logic                        drained,
   output logic                        done
);

   localparam int            CW      = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 1);

   logic [WIDTH-1:0] q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             in_right, in_left;

   // In rotate mode the bit falling off one end re-enters at the other end
   assign in_right = ROTATE ? q[0]       : sin_msb;
   assign in_left  = ROTATE ? q[WIDTH-1] : sin_lsb;

   // Next-state selection for data, counter and done pulse
   always_comb begin
      q_d    = q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (enable) begin
         case (mode)
            MODE_SHR, MODE_SHL: begin
               q_d = (mode == MODE_SHR) ? {in_right, q[WIDTH-1:1]}
                                        : {q[WIDTH-2:0], in_left};
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               done_d = (cnt_q == CNT_PRE);
            end
            MODE_LOAD: begin
               q_d   = d;
               cnt_d = '0;
            end
            default: begin
            end
         endcase
      end
   end

   // One storage cell per bit; holding is handled by the next-state mux
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      dff_en_cell #(
         .RESET_BIT (RESET_VALUE[g])
      ) u_cell (
         .clock   (clock),
         .reset_n (reset_n),
         .en_i    (enable),
         .d_i     (q_d[g]),
         .q_o     (q[g])
      );
   end

   // Counter starts saturated after reset so a reset register reads as drained
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q  <= CNT_MAX;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign shift_cnt = cnt_q;
   assign done      = done_q;
   assign drained   = (cnt_q == CNT_MAX);
   assign sout_lsb  = q[0];
   assign sout_msb  = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - vector table and scoreboard bench for universal_shift_reg
module tb_universal_shift_reg;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic [1:0] mode;
      logic [7:0] d;
      logic       smsb;
      logic       slsb;
      logic [7:0] eq;
      logic [3:0] ec;
      logic       ed;
   } vec_t;

   typedef struct {
      int         dut;
      int         idx;
      logic [7:0] eq;
      logic [3:0] ec;
      logic       ed;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] d = 8'h00;
   logic       sin_msb = 1'b0;
   logic       sin_lsb = 1'b0;

   logic [7:0] q0, q1;
   logic       sl0, sm0, sl1, sm1, dr0, dr1, dn0, dn1;
   logic [3:0] c0, c1;

   int n_checks = 0;
   int n_fail = 0;

   vec_t vecs[$];
   exp_t sb[$];

   always #5 clock = ~clock;

   universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5), .ROTATE(1'b0)) dut0 (
      .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode), .d(d),
      .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q0), .sout_lsb(sl0), .sout_msb(sm0),
      .shift_cnt(c0), .drained(dr0), .done(dn0));

   universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00), .ROTATE(1'b1)) dut1 (
      .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode), .d(d),
      .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q1), .sout_lsb(sl1), .sout_msb(sm1),
      .shift_cnt(c1), .drained(dr1), .done(dn1));

   function automatic vec_t mk(input logic rst_n, input logic en, input logic [1:0] md,
                               input logic [7:0] dd, input logic smsb, input logic slsb,
                               input logic [7:0] eq, input logic [3:0] ec, input logic ed);
      vec_t t;
      t.rst_n = rst_n; t.en = en; t.mode = md; t.d = dd; t.smsb = smsb; t.slsb = slsb;
      t.eq = eq; t.ec = ec; t.ed = ed;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle, queue the expectation, then compare just after the edge
   task automatic apply(input int dut, input int idx, input vec_t t);
      exp_t e;
      exp_t want;
      @(negedge clock);
      reset_n = t.rst_n; enable = t.en; mode = t.mode; d = t.d;
      sin_msb = t.smsb; sin_lsb = t.slsb;
      want.dut = dut; want.idx = idx; want.eq = t.eq; want.ec = t.ec; want.ed = t.ed;
      sb.push_back(want);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      if (e.dut == 0) begin
         check("q0", e.idx, q0, e.eq);
         check("cnt0", e.idx, {4'h0, c0}, {4'h0, e.ec});
         check("done0", e.idx, {7'h0, dn0}, {7'h0, e.ed});
         check("drained0", e.idx, {7'h0, dr0}, {7'h0, (e.ec == 4'd8)});
         check("sout_lsb0", e.idx, {7'h0, sl0}, {7'h0, e.eq[0]});
         check("sout_msb0", e.idx, {7'h0, sm0}, {7'h0, e.eq[7]});
      end else begin
         check("q1", e.idx, q1, e.eq);
         check("cnt1", e.idx, {4'h0, c1}, {4'h0, e.ec});
         check("done1", e.idx, {7'h0, dn1}, {7'h0, e.ed});
         check("sout_lsb1", e.idx, {7'h0, sl1}, {7'h0, e.eq[0]});
      end
   endtask

   initial begin
      logic [7:0] sipo_pat;
      logic [7:0] sipo_q [8];
      logic [7:0] sat_q [10];

      // Reset held for two edges
      vecs.push_back(mk(0, 0, 2'b00, 8'h00, 0, 0, 8'hA5, 4'd8, 0));
      vecs.push_back(mk(0, 0, 2'b00, 8'h00, 0, 0, 8'hA5, 4'd8, 0));
      // Load then PISO right shifts
      vecs.push_back(mk(1, 1, 2'b11, 8'hC3, 0, 0, 8'hC3, 4'd0, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h61, 4'd1, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h30, 4'd2, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h18, 4'd3, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h0C, 4'd4, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h06, 4'd5, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h03, 4'd6, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h01, 4'd7, 0));
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 4'd8, 1));
      // Shifting while drained keeps shifting without a pulse
      vecs.push_back(mk(1, 1, 2'b01, 8'h00, 1, 0, 8'h80, 4'd8, 0));
      vecs.push_back(mk(1, 1, 2'b00, 8'hFF, 0, 1, 8'h80, 4'd8, 0));
      // SIPO left shifts of pattern 1,0,1,1,0,0,1,0
      vecs.push_back(mk(1, 1, 2'b11, 8'h00, 0, 0, 8'h00, 4'd0, 0));
      sipo_pat = 8'b1011_0010;
      sipo_q[0] = 8'h01; sipo_q[1] = 8'h02; sipo_q[2] = 8'h05; sipo_q[3] = 8'h0B;
      sipo_q[4] = 8'h16; sipo_q[5] = 8'h2C; sipo_q[6] = 8'h59; sipo_q[7] = 8'hB2;
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, sipo_pat[7-i], sipo_q[i], 4'(i + 1), (i == 7)));
      end
      // Enable low blocks load and shift
      vecs.push_back(mk(1, 0, 2'b11, 8'hFF, 0, 0, 8'hB2, 4'd8, 0));
      vecs.push_back(mk(1, 0, 2'b01, 8'hFF, 1, 1, 8'hB2, 4'd8, 0));
      // Reset beats an enabled load
      vecs.push_back(mk(0, 1, 2'b11, 8'hFF, 0, 0, 8'hA5, 4'd8, 0));
      // Load after seven shifts: counter clears, no pulse
      vecs.push_back(mk(1, 1, 2'b11, 8'h00, 0, 0, 8'h00, 4'd0, 0));
      vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, 1, 8'h01, 4'd1, 0));
      vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, 1, 8'h03, 4'd2, 0));
      vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, 1, 8'h07, 4'd3, 0));
      vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, 1, 8'h0F, 4'd4, 0));
      vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, 1, 8'h1F, 4'd5, 0));
      vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, 1, 8'h3F, 4'd6, 0));
      vecs.push_back(mk(1, 1, 2'b10, 8'h00, 0, 1, 8'h7F, 4'd7, 0));
      vecs.push_back(mk(1, 1, 2'b11, 8'h5A, 0, 1, 8'h5A, 4'd0, 0));
      // Ten right shifts: counter saturates, exactly one pulse
      sat_q[0] = 8'hAD; sat_q[1] = 8'hD6; sat_q[2] = 8'hEB; sat_q[3] = 8'hF5; sat_q[4] = 8'hFA;
      sat_q[5] = 8'hFD; sat_q[6] = 8'hFE; sat_q[7] = 8'hFF; sat_q[8] = 8'hFF; sat_q[9] = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         vecs.push_back(mk(1, 1, 2'b01, 8'h00, 1, 0, sat_q[i], (i < 8) ? 4'(i + 1) : 4'd8, (i == 7)));
      end

      for (int i = 0; i < vecs.size(); i++) begin
         apply(0, i, vecs[i]);
      end

      // Rotate instance: serial inputs are set opposite to the wrapped bit
      apply(1, 100, mk(1, 1, 2'b11, 8'h81, 1, 1, 8'h81, 4'd0, 0));
      apply(1, 101, mk(1, 1, 2'b01, 8'h00, 0, 1, 8'hC0, 4'd1, 0));
      apply(1, 102, mk(1, 1, 2'b10, 8'h00, 1, 0, 8'h81, 4'd2, 0));
      apply(1, 103, mk(1, 1, 2'b10, 8'h00, 0, 0, 8'h03, 4'd3, 0));
      apply(1, 104, mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h81, 4'd4, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
